// File: rtl/image_rom_reader.sv
// Raster-scan ROM read sequencer: row-major pixels as a tagged valid/ready stream. Latency start->m_valid 3 cycles.
// Backpressure: m_ready low stalls issue once 2 reads are buffered/in flight; m_* hold until the pop.
module image_rom_reader #(
    parameter int WIDTH  = 960,
    parameter int HEIGHT = 720,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [10:0]       m_x,
    output logic [9:0]        m_y,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [10:0]       X_LAST    = 11'(WIDTH - 1);
    localparam logic [9:0]        Y_LAST    = 10'(HEIGHT - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [10:0]       x;
        logic [9:0]        y;
        logic              sof;
        logic              eol;
        logic              eof;
    } pix_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic        rd_en, inflight, rd_all, push, pop;
    logic [10:0] rx;
    logic [9:0]  ry;
    pix_t        fifo_mem [2];
    pix_t        head, wr_pix;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;

    assign head    = fifo_mem[rd_ptr];
    assign m_valid = (count != 2'd0);
    assign pop     = m_valid & m_ready;
    assign push    = inflight;
    assign busy    = (state == RUN);

    assign m_data  = head.data;
    assign m_x     = head.x;
    assign m_y     = head.y;
    assign m_sof   = head.sof;
    assign m_eol   = head.eol;
    assign m_eof   = head.eof;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (pop && head.eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so issue never stalls at full rate.
    always_comb begin
        rd_en = (state == RUN) && !rd_all &&
                (((count + {1'b0, inflight}) < 2'd2) || pop);
    end

    always_comb begin
        wr_pix      = '0;
        wr_pix.data = rom_dout;
        wr_pix.x    = rx;
        wr_pix.y    = ry;
        wr_pix.sof  = (rx == '0) && (ry == '0);
        wr_pix.eol  = (rx == X_LAST);
        wr_pix.eof  = (rx == X_LAST) && (ry == Y_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            done        <= 1'b0;
            inflight    <= 1'b0;
            rd_all      <= 1'b0;
            rom_addr    <= '0;
            rx          <= '0;
            ry          <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == RUN) && (state_nxt == IDLE);
            inflight <= rd_en;

            if (state == IDLE && start) begin
                rom_addr <= '0;
                rx       <= '0;
                ry       <= '0;
                rd_all   <= 1'b0;
            end else begin
                if (rd_en) begin
                    rom_addr <= rom_addr + 1'b1;
                    if (rom_addr == ADDR_LAST) rd_all <= 1'b1;
                end
                if (push) begin
                    if (rx == X_LAST) begin
                        rx <= '0;
                        ry <= ry + 1'b1;
                    end else begin
                        rx <= rx + 1'b1;
                    end
                end
            end

            if (push) begin
                fifo_mem[wr_ptr] <= wr_pix;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
